refresh_scheduler: RTL
======================

Name: refresh_scheduler

Overview:
- Parametrised successor to the fixed 64 ms free-running refresh counter in the DDR3 top level.
- Generates periodic REF requests every tREFI to the memory-controller state machine over a req/ack handshake.
- Tracks a signed refresh balance. Supports up to MAX_POSTPONE postponed refreshes and up to MAX_PULLIN pulled-in refreshes, the latter issued opportunistically while the controller is idle.
- Sits between the clock-generator output domain and the main controller state machine. Replaces the raw Refresh level.

Parameters:
- TREFI_CYCLES, 2496, clk cycles per refresh interval (7.8 us at 320 MHz); legal range 4..65535.
- MAX_POSTPONE, 8, maximum outstanding (owed) refreshes before a violation; legal range 1..8.
- MAX_PULLIN, 8, maximum refreshes issued ahead of schedule; 0 disables pull-in; legal range 0..8.
- CNT_W, 16, interval counter width; must satisfy 2^CNT_W >= TREFI_CYCLES.
- BAL_W, 5, signed balance width; must hold -MAX_PULLIN..+MAX_POSTPONE.

Ports:
- clk  input  1  controller clock (320 MHz MMCM output).
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  high once DRAM init (ZQCL/MRS) is complete; low holds the block idle.
- ctrl_idle  input  1  controller is in IDLE with all banks precharged; qualifies pull-in.
- ref_ack  input  1  one-cycle pulse: controller issued a REF command this cycle.
- ref_req  output  1  a refresh is wanted (owed or opportunistic).
- ref_urgent  output  1  balance has reached MAX_POSTPONE; controller must refresh before any new ACT.
- balance  output  BAL_W  signed: positive = refreshes owed, negative = refreshes pulled in.
- tick  output  1  one-cycle pulse at each tREFI boundary.
- viol_err  output  1  sticky: a refresh-window violation occurred.
- ack_err  output  1  sticky: ref_ack arrived while ref_req was low.

Behaviour:
- Reset (rst_n low, async): counter=0, balance=0; ref_req, ref_urgent, tick, viol_err and ack_err all 0. Registers update on the posedge after rst_n release.
- enable low: counter and balance are synchronously forced to 0, ref_req and ref_urgent are 0, and tick does not fire. The sticky errors hold their value.
- Interval counter:
  - When enabled, counts 0..TREFI_CYCLES-1 and wraps to 0.
  - tick is registered: it is high during the cycle after the counter holds TREFI_CYCLES-1.
  - The first tick arrives TREFI_CYCLES cycles after enable rises.
- Balance update, once per cycle, from the inputs sampled at that edge:
  - tick only: balance+1.
  - ack only: balance-1.
  - tick and ack together: no change.
  - Neither: no change.
- Saturation:
  - If tick would take balance above MAX_POSTPONE, balance stays at MAX_POSTPONE and viol_err sets.
  - An ack that would take balance below -MAX_PULLIN is ignored and ack_err sets. This case is unreachable if the controller obeys ref_req.
- Outputs (combinational from the registers and ctrl_idle):
  - ref_req = enable AND ( balance>0 OR (ctrl_idle AND MAX_PULLIN>0 AND balance>-MAX_PULLIN) ).
  - ref_urgent = enable AND balance>=MAX_POSTPONE.
- Handshake:
  - ref_req stays high until the balance condition clears. A single ack lowers balance by exactly 1.
  - ack accepted while ref_req=1 is legal, including opportunistic acks.
  - ack while ref_req=0 is ignored (balance unchanged) and sets ack_err.
  - There is no required latency from ref_req to ref_ack. The controller may delay while balance < MAX_POSTPONE.
- State (internal, exported only via outputs), priority top-down:
  - DISABLED: enable=0.
  - URGENT: balance>=MAX_POSTPONE.
  - OWED: balance>0.
  - AHEAD: balance<0.
  - IN_SYNC: balance=0.
- Boundary conditions:
  - A tick in the same cycle the balance reaches saturation, combined with ack, gives a net 0 with no error.
  - If enable falls mid-interval and rises again, the interval restarts from 0. The balance is lost by design, because DRAM is re-initialised.
  - Arithmetic is two's-complement at BAL_W. The balance output is sign-extended by the consumer.

Test Plan:
- TREFI_CYCLES=16, rst_n low then high, enable=1, no ack, ctrl_idle=0 -> first tick 16 cycles after enable; balance reaches 1 at the tick edge and ref_req=1.
- Ack withheld for 8 ticks (MAX_POSTPONE=8) -> balance=8 and ref_urgent=1. A 9th tick leaves balance at 8 and sets viol_err.
- balance=3, pulse ref_ack three times -> balance 2,1,0 on successive edges; ref_req falls with balance=0 (ctrl_idle=0).
- balance=0, ctrl_idle=1, controller acks every request, no ticks -> balance goes to -8 (MAX_PULLIN=8) and then ref_req=0. The next tick gives balance=-7.
- tick and ref_ack in the same cycle at balance=8 -> balance stays 8, viol_err stays 0. An ack with ref_req=0 (balance=0, ctrl_idle=0) -> ack_err=1 and balance stays 0.
- Assert rst_n low mid-interval with balance=5 -> all outputs 0 immediately (async). Separately, drop enable with balance=5 -> balance=0 next edge, sticky errors preserved.

Source files
------------

// File: rtl/refresh_scheduler.sv
// Periodic DRAM refresh scheduler: tREFI interval timer, signed refresh balance, req/ack to the controller.
// Latency: tick one cycle after the counter hits TREFI_CYCLES-1; balance updates the edge after tick/ack are seen.
// Backpressure: controller may hold off ref_ack while balance < MAX_POSTPONE; ref_urgent flags the hard limit.
module refresh_scheduler #(
   parameter int TREFI_CYCLES = 2496,
   parameter int MAX_POSTPONE = 8,
   parameter int MAX_PULLIN   = 8,
   parameter int CNT_W        = 16,
   parameter int BAL_W        = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             ctrl_idle,
   input  logic             ref_ack,
   output logic             ref_req,
   output logic             ref_urgent,
   output logic [BAL_W-1:0] balance,
   output logic             tick,
   output logic             viol_err,
   output logic             ack_err
);

   // Interval counter constants.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TREFI_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Balance limits in the register's own two's-complement width.
   localparam logic signed [BAL_W-1:0] BAL_ZERO = '0;
   localparam logic signed [BAL_W-1:0] BAL_ONE  = BAL_W'(1);
   localparam logic signed [BAL_W-1:0] BAL_MAX  = BAL_W'(MAX_POSTPONE);
   localparam logic signed [BAL_W-1:0] BAL_MIN  = BAL_W'(-MAX_PULLIN);
   localparam bit                      PULLIN_EN = (MAX_PULLIN > 0);

   // Scheduler condition, derived from enable and the balance.
   typedef enum logic [2:0] {
      ST_DISABLED = 3'd0,
      ST_IN_SYNC  = 3'd1,
      ST_AHEAD    = 3'd2,
      ST_OWED     = 3'd3,
      ST_URGENT   = 3'd4
   } state_t;

   logic [CNT_W-1:0]        cnt_q;
   logic                    tick_q;
   logic signed [BAL_W-1:0] bal_q;
   logic signed [BAL_W-1:0] bal_nxt;
   state_t                  state_q;
   logic                    viol_q;
   logic                    ack_err_q;

   logic                    owed;
   logic                    pull_ok;
   logic                    req_int;
   logic                    ack_ok;
   logic                    ack_bad;
   logic                    tick_sat;

   // Free-running tREFI timer; restarts from zero whenever enable drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else if (!enable) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= (cnt_q == CNT_LAST);
         if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_ONE;
         end
      end
   end

   // Request qualification: owed refreshes always, pull-in only when the controller is idle.
   always_comb begin
      owed    = (state_q == ST_OWED) || (state_q == ST_URGENT);
      pull_ok = PULLIN_EN && ctrl_idle && (bal_q > BAL_MIN);
      req_int = rst_n && enable && (owed || pull_ok);
   end

   // Next balance: tick adds one, an accepted ack removes one, both together cancel.
   always_comb begin
      bal_nxt  = bal_q;
      tick_sat = 1'b0;
      // The lower-limit term is redundant with req_int but keeps the balance from wrapping.
      ack_ok   = ref_ack && req_int && (bal_q > BAL_MIN);
      ack_bad  = enable && ref_ack && !ack_ok;
      if (tick_q && !ack_ok) begin
         if (bal_q >= BAL_MAX) begin
            tick_sat = enable;
         end else begin
            bal_nxt = bal_q + BAL_ONE;
         end
      end else if (ack_ok && !tick_q) begin
         bal_nxt = bal_q - BAL_ONE;
      end
   end

   // Balance register; the owed count is discarded when DRAM is taken down.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bal_q <= BAL_ZERO;
      end else if (!enable) begin
         bal_q <= BAL_ZERO;
      end else begin
         bal_q <= bal_nxt;
      end
   end

   // Condition register tracks the balance that is being loaded this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_DISABLED;
      end else if (!enable) begin
         state_q <= ST_DISABLED;
      end else if (bal_nxt >= BAL_MAX) begin
         state_q <= ST_URGENT;
      end else if (bal_nxt > BAL_ZERO) begin
         state_q <= ST_OWED;
      end else if (bal_nxt < BAL_ZERO) begin
         state_q <= ST_AHEAD;
      end else begin
         state_q <= ST_IN_SYNC;
      end
   end

   // Sticky error flags; they only clear on reset and survive enable toggling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         viol_q    <= 1'b0;
         ack_err_q <= 1'b0;
      end else begin
         viol_q    <= viol_q | tick_sat;
         ack_err_q <= ack_err_q | ack_bad;
      end
   end

   // Output drive; enable gating keeps everything quiet while the DRAM is down.
   always_comb begin
      ref_req    = req_int;
      ref_urgent = rst_n && enable && (state_q == ST_URGENT);
      balance    = bal_q;
      tick       = tick_q && enable;
      viol_err   = viol_q;
      ack_err    = ack_err_q;
   end

endmodule
